// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the parametrised VGA timing generator:
// per-axis mode tables and the helper that derives line/frame totals.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] sync;
        logic [15:0] bp;
        logic [15:0] active;
        logic [15:0] fp;
    } axis_timing_t;

    // 800x600 @ 72 Hz, 50 MHz pixel clock
    localparam axis_timing_t SVGA_800_H = '{sync: 16'd120, bp: 16'd64, active: 16'd800, fp: 16'd56};
    localparam axis_timing_t SVGA_800_V = '{sync: 16'd6,   bp: 16'd23, active: 16'd600, fp: 16'd37};

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam axis_timing_t VGA_640_H  = '{sync: 16'd96,  bp: 16'd48, active: 16'd640, fp: 16'd16};
    localparam axis_timing_t VGA_640_V  = '{sync: 16'd2,   bp: 16'd33, active: 16'd480, fp: 16'd10};

    function automatic int axis_total(input int sync, input int bp, input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Pixel-source and video-pin bundle of the timing generator; the generator
// is the master, the consumer of video and supplier of pixel data is the slave.
interface vga_timing_if #(
    parameter int DW = 12,
    parameter int CW = 12
);
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    logic [DW-1:0] pix_data;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [DW-1:0] rgb;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_req, pix_x, pix_y, hsync, vsync, de, rgb, line_start, frame_start,
        input  pix_data
    );

    modport slave (
        input  pix_req, pix_x, pix_y, hsync, vsync, de, rgb, line_start, frame_start,
        output pix_data
    );
endinterface

// File: rtl/vga_axis_cnt.sv
// Wrapping position counter for one screen axis; wrap flags the step that
// returns the count to zero so the next axis can be chained off it.
module vga_axis_cnt #(
    parameter int TOTAL = 1040,
    parameter int CW    = 12
) (
    input  logic          vga_clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap
);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    assign wrap = inc && (cnt == LAST);

    always_ff @(posedge vga_clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: sync/de timing from one pixel clock plus
// pixel requests issued early enough to hide the source read latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC   = int'(SVGA_800_H.sync),
    parameter int H_BP     = int'(SVGA_800_H.bp),
    parameter int H_ACTIVE = int'(SVGA_800_H.active),
    parameter int H_FP     = int'(SVGA_800_H.fp),
    parameter int V_SYNC   = int'(SVGA_800_V.sync),
    parameter int V_BP     = int'(SVGA_800_V.bp),
    parameter int V_ACTIVE = int'(SVGA_800_V.active),
    parameter int V_FP     = int'(SVGA_800_V.fp),
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int DW       = 12,
    parameter int CW       = 12,
    parameter int RD_LAT   = 1
) (
    input  logic         vga_clk,
    input  logic         rst,
    input  logic         en,
    vga_timing_if.master vif
);
    localparam int H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int HA      = H_SYNC + H_BP;
    localparam int VA      = V_SYNC + V_BP;
    localparam int RQ      = HA - RD_LAT - 1;
    localparam int CW1     = CW + 1;

    // Region bounds carry one spare bit so an end bound equal to 2^CW stays exact.
    localparam logic [CW:0] HS_END = CW1'(H_SYNC);
    localparam logic [CW:0] HA_BEG = CW1'(HA);
    localparam logic [CW:0] HA_END = CW1'(HA + H_ACTIVE);
    localparam logic [CW:0] RQ_BEG = CW1'(RQ);
    localparam logic [CW:0] RQ_END = CW1'(RQ + H_ACTIVE);
    localparam logic [CW:0] VS_END = CW1'(V_SYNC);
    localparam logic [CW:0] VA_BEG = CW1'(VA);
    localparam logic [CW:0] VA_END = CW1'(VA + V_ACTIVE);

    localparam logic [CW-1:0] RQ_ORG = CW'(RQ);
    localparam logic [CW-1:0] VA_ORG = CW'(VA);

    // ---- stage p0: screen position counters ----
    logic          vld_p0;
    logic          clr_p0;
    logic [CW-1:0] h_p0;
    logic [CW-1:0] v_p0;
    logic          h_wrap_p0;
    logic          frame_wrap_unused;

    assign vld_p0 = !rst && en;
    assign clr_p0 = !en;

    vga_axis_cnt #(.TOTAL(H_TOTAL), .CW(CW)) u_h_cnt (
        .vga_clk (vga_clk),
        .rst     (rst),
        .clr     (clr_p0),
        .inc     (1'b1),
        .cnt     (h_p0),
        .wrap    (h_wrap_p0)
    );

    vga_axis_cnt #(.TOTAL(V_TOTAL), .CW(CW)) u_v_cnt (
        .vga_clk (vga_clk),
        .rst     (rst),
        .clr     (clr_p0),
        .inc     (h_wrap_p0),
        .cnt     (v_p0),
        .wrap    (frame_wrap_unused)
    );

    logic [CW:0]   h_ext_p0;
    logic [CW:0]   v_ext_p0;
    logic          hs_act_p0;
    logic          vs_act_p0;
    logic          row_act_p0;
    logic          de_p0;
    logic          req_p0;
    logic [CW-1:0] px_p0;
    logic [CW-1:0] py_p0;

    assign h_ext_p0   = {1'b0, h_p0};
    assign v_ext_p0   = {1'b0, v_p0};
    assign hs_act_p0  = h_ext_p0 < HS_END;
    assign vs_act_p0  = v_ext_p0 < VS_END;
    assign row_act_p0 = (v_ext_p0 >= VA_BEG) && (v_ext_p0 < VA_END);
    assign de_p0      = row_act_p0 && (h_ext_p0 >= HA_BEG) && (h_ext_p0 < HA_END);
    // Requests run RD_LAT+1 pixels ahead of de: RD_LAT for the source, one for the rgb register.
    assign req_p0     = row_act_p0 && (h_ext_p0 >= RQ_BEG) && (h_ext_p0 < RQ_END);
    assign px_p0      = h_p0 - RQ_ORG;
    assign py_p0      = v_p0 - VA_ORG;

    // ---- stage p1: registered, mutually aligned outputs ----
    always_ff @(posedge vga_clk) begin
        if (!vld_p0) begin
            vif.hsync       <= !HS_POL;
            vif.vsync       <= !VS_POL;
            vif.de          <= 1'b0;
            vif.rgb         <= '0;
            vif.pix_req     <= 1'b0;
            vif.pix_x       <= '1;
            vif.pix_y       <= '1;
            vif.line_start  <= 1'b0;
            vif.frame_start <= 1'b0;
        end else begin
            vif.hsync       <= hs_act_p0 ? HS_POL : !HS_POL;
            vif.vsync       <= vs_act_p0 ? VS_POL : !VS_POL;
            vif.de          <= de_p0;
            vif.rgb         <= de_p0 ? vif.pix_data : '0;
            vif.pix_req     <= req_p0;
            vif.pix_x       <= req_p0 ? px_p0 : '1;
            vif.pix_y       <= req_p0 ? py_p0 : '1;
            vif.line_start  <= (h_p0 == '0);
            vif.frame_start <= (h_p0 == '0) && (v_p0 == '0);
        end
    end
endmodule
